// File: rtl/div_frac_pkg.sv
// Shared constants and state encoding for the restoring mantissa divider.
// Quotient weight: bit WIDTH is 2^0, bit 0 is 2^-(WIDTH).
package div_frac_pkg;

    localparam int WIDTH = 24;
    localparam int CNT_W = 5;
    localparam int ITERS = WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_frac_add.sv
// Small modular adder shared by the iteration counters.
// The divider feeds in2 = all ones to decrement.
module adder_5bit (
    input  logic [4:0] in1,
    input  logic [4:0] in2,
    output logic [4:0] sum
);

    // Sum wraps modulo 32; carry out is not needed by any user.
    assign sum = in1 + in2;

endmodule

// File: rtl/div_frac_sub.sv
// Trial subtraction for the divider: difference and borrow out.
// Counterpart of the 48-bit mantissa product adder.
module subtractor_25bit
    import div_frac_pkg::*;
(
    input  logic [WIDTH:0] in1,
    input  logic [WIDTH:0] in2,
    output logic [WIDTH:0] D,
    output logic           Bout
);

    // Extend by one bit so the top bit of the result is the borrow.
    assign {Bout, D} = {1'b0, in1} - {1'b0, in2};

endmodule

// File: rtl/div_frac.sv
// Sequential restoring divider for 1.23 mantissas, one quotient bit
// per clock, with normalize flag, sticky bit and divide-by-zero flag.
module div_frac
    import div_frac_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] out,
    output logic             norm,
    output logic             sticky,
    output logic             dz,
    output logic             busy,
    output logic             enaout
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH:0]   r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dz;

    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic [CNT_W-1:0] w_cnt_dec;
    logic             w_accept;
    logic             w_iter;
    logic             w_bzero;

    assign w_accept = start && (r_state != S_RUN);
    assign w_bzero  = (B == '0);

    subtractor_25bit u_sub (
        .in1  (r_rem),
        .in2  ({1'b0, r_div}),
        .D    (w_diff),
        .Bout (w_borrow)
    );

    adder_5bit u_cnt (
        .in1 (r_cnt),
        .in2 ({CNT_W{1'b1}}),
        .sum (w_cnt_dec)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next state, iteration enable and gated result outputs.
    always_comb begin
        w_next = r_state;
        w_iter = 1'b0;
        busy   = 1'b0;
        enaout = 1'b0;
        out    = '0;
        norm   = 1'b0;
        sticky = 1'b0;
        dz     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                // A zero count on entry marks a divide by zero.
                if (r_cnt == '0) begin
                    w_next = S_DONE;
                end else begin
                    w_iter = 1'b1;
                    if (r_cnt == CNT_W'(1)) w_next = S_DONE;
                end
            end
            S_DONE: begin
                enaout = 1'b1;
                dz     = r_dz;
                if (start) w_next = S_RUN;
                if (!r_dz) begin
                    if (r_quo[WIDTH]) begin
                        out    = r_quo[WIDTH:1];
                        sticky = (|r_rem) | r_quo[0];
                    end else begin
                        out    = r_quo[WIDTH-1:0];
                        norm   = 1'b1;
                        sticky = |r_rem;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture on accept, then one restoring step per clock.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
            r_cnt <= '0;
            r_dz  <= 1'b0;
        end else if (w_accept) begin
            r_rem <= {1'b0, A};
            r_div <= B;
            r_quo <= '0;
            r_dz  <= w_bzero;
            r_cnt <= w_bzero ? '0 : CNT_W'(ITERS);
        end else if (w_iter) begin
            r_quo <= {r_quo[WIDTH-1:0], ~w_borrow};
            r_rem <= w_borrow ? {r_rem[WIDTH-1:0], 1'b0}
                              : {w_diff[WIDTH-1:0], 1'b0};
            r_cnt <= w_cnt_dec;
        end
    end

endmodule

// File: tb/tb_div_frac.sv
// Scoreboard bench for div_frac: reference quotients come from
// plain integer division of the scaled dividend.
module tb_div_frac;
    import div_frac_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start = 1'b0;
    logic [23:0] A = '0;
    logic [23:0] B = '0;
    logic [23:0] out;
    logic        norm, sticky, dz, busy, enaout;

    div_frac dut (
        .CLK    (CLK),
        .RST    (RST),
        .start  (start),
        .A      (A),
        .B      (B),
        .out    (out),
        .norm   (norm),
        .sticky (sticky),
        .dz     (dz),
        .busy   (busy),
        .enaout (enaout)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [23:0] out;
        logic        norm;
        logic        sticky;
        logic        dz;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_ena = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [23:0] a,
                                   input logic [23:0] b, input int acc);
        exp_t e;
        logic [48:0] num, q, r;
        e.out = '0; e.norm = 1'b0; e.sticky = 1'b0; e.dz = 1'b0;
        e.due = acc + 25;
        if (b == 0) begin
            e.dz  = 1'b1;
            e.due = acc + 1;
        end else begin
            num = {1'b0, a, 24'h0};
            q = num / {25'h0, b};
            r = num % {25'h0, b};
            if (q[24]) begin
                e.out    = q[24:1];
                e.sticky = (r != 0) || q[0];
            end else begin
                e.out    = q[23:0];
                e.norm   = 1'b1;
                e.sticky = (r != 0);
            end
        end
        return e;
    endfunction

    // Monitor: pop and compare on each new result.
    always @(negedge CLK) begin
        exp_t e;
        if (RST) begin
            if (busy && enaout) chk("busy_and_enaout", 32'(1), 32'(0));
            if (!enaout) begin
                if (out != 0 || norm || sticky || dz)
                    chk("idle_outputs_zero",
                        32'({out, norm, sticky, dz}), 32'(0));
            end
            if (enaout && !prev_ena) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    chk("out", 32'(out), 32'(e.out));
                    chk("norm", 32'(norm), 32'(e.norm));
                    chk("sticky", 32'(sticky), 32'(e.sticky));
                    chk("dz", 32'(dz), 32'(e.dz));
                    chk("latency", 32'(cyc), 32'(e.due));
                end
            end
        end
        prev_ena = enaout;
    end

    task automatic issue(input logic [23:0] a, input logic [23:0] b);
        int n = 0;
        @(negedge CLK);
        while (busy && n < 60) begin
            @(negedge CLK);
            n++;
        end
        A = a; B = b; start = 1'b1;
        sb.push_back(model(a, b, cyc + 1));
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, 32'({out, norm, sticky, dz, busy, enaout}), 32'(0));
    endtask

    initial begin
        logic [23:0] ra, rb;
        int n;

        repeat (2) @(negedge CLK);
        chk_all_zero("reset_outputs");
        RST = 1'b1;

        issue(24'h800000, 24'h800000);
        wait_done();
        issue(24'h800000, 24'hC00000);
        wait_done();
        issue(24'hFFFFFF, 24'h800000);
        wait_done();

        issue(24'h900000, 24'h000000);
        chk("dz_busy_first", 32'(busy), 32'(1));
        @(negedge CLK);
        chk("dz_busy_released", 32'(busy), 32'(0));
        wait_done();

        issue(24'hA5A5A5, 24'hB00001);
        repeat (5) @(negedge CLK);
        A = 24'h812345; B = 24'hFEDCBA; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_done();

        issue(24'h800000, 24'hC00000);
        repeat (3) @(negedge CLK);
        A = 24'hF00000; B = 24'h900000; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (5) @(negedge CLK);
        RST = 1'b0;
        #1;
        chk_all_zero("abort_outputs");
        sb.delete();
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        issue(24'h800000, 24'h800000);
        wait_done();

        issue(24'h800000, 24'h800000);
        n = 0;
        while (!enaout && n < 40) begin
            @(negedge CLK);
            n++;
        end
        A = 24'hFFFFFF; B = 24'h800000; start = 1'b1;
        sb.push_back(model(24'hFFFFFF, 24'h800000, cyc + 1));
        @(negedge CLK);
        start = 1'b0;
        chk("b2b_enaout_drop", 32'(enaout), 32'(0));
        wait_done();

        for (int i = 0; i < 30; i++) begin
            ra = 24'h800000 | 24'($urandom & 32'h7FFFFF);
            rb = 24'h800000 | 24'($urandom & 32'h7FFFFF);
            if ($urandom_range(0, 7) == 0) rb = '0;
            issue(ra, rb);
            if ($urandom_range(0, 1) == 0) wait_done();
        end
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
